// File: rtl/tag_alloc_if.sv
// Allocation/release handshake bundle for tag_alloc.
// The allocator side uses the slave modport; the consumer/return path uses master.
interface tag_alloc_if #(
  parameter int W = 32
);
  localparam int LW = $clog2(W);

  logic          alloc_vld_o;
  logic [LW-1:0] alloc_tag_o;
  logic          alloc_rdy_i;
  logic          free_vld_i;
  logic [LW-1:0] free_tag_i;

  modport slave (
    output alloc_vld_o,
    output alloc_tag_o,
    input  alloc_rdy_i,
    input  free_vld_i,
    input  free_tag_i
  );

  modport master (
    input  alloc_vld_o,
    input  alloc_tag_o,
    output alloc_rdy_i,
    output free_vld_i,
    output free_tag_i
  );
endinterface

// File: rtl/tag_alloc.sv
// Circular tag allocator: hands out free tags in descending round-robin order
// from an occupancy vector, keeping one pre-reserved tag in an output stage.
module tag_alloc #(
  parameter int W       = 32,
  parameter int RADIX_N = 4
) (
  input  logic                clk,
  input  logic                arst_n,
  tag_alloc_if.slave          bus,
  output logic [W-1:0]        busy_o,
  output logic [$clog2(W):0]  cnt_o,
  output logic                full_o,
  output logic                err_o
);
  localparam int LW = $clog2(W);

  function automatic int clogRadix(input int n, input int r);
    int l;
    int p;
    l = 0;
    p = 1;
    while (p < n) begin
      p = p * r;
      l = l + 1;
    end
    return l;
  endfunction

  localparam int LEVELS = clogRadix(W, RADIX_N);

  // Radix-N reduction tree returning {any, index of the highest set bit}.
  function automatic logic [LW:0] leftMostOne(input logic [W-1:0] v);
    logic [W-1:0]  anyV;
    logic [LW-1:0] idxV [W];
    logic [W-1:0]  nAny;
    logic [LW-1:0] nIdx [W];
    anyV = v;
    for (int i = 0; i < W; i++) begin
      idxV[i] = LW'(i);
    end
    for (int lvl = 0; lvl < LEVELS; lvl++) begin
      nAny = '0;
      for (int i = 0; i < W; i++) begin
        nIdx[i] = '0;
      end
      for (int k = 0; k < W; k++) begin
        if (anyV[k]) begin
          nAny[k / RADIX_N] = 1'b1;
          nIdx[k / RADIX_N] = idxV[k];
        end
      end
      anyV = nAny;
      for (int i = 0; i < W; i++) begin
        idxV[i] = nIdx[i];
      end
    end
    return {anyV[0], idxV[0]};
  endfunction

  logic [W-1:0]  r_busy;
  logic          r_stgVld;
  logic [LW-1:0] r_stgTag;
  logic [LW-1:0] r_ptr;
  logic          r_err;

  logic [W-1:0]  w_free;
  logic [W-1:0]  w_mask;
  logic [LW:0]   w_loRes;
  logic [LW:0]   w_allRes;
  logic          w_any;
  logic [LW-1:0] w_enc;
  logic          w_take;
  logic          w_fill;
  logic          w_freeLegal;
  logic [W-1:0]  w_busyNxt;
  logic [LW:0]   w_pop;

  // Bits strictly below the pointer are searched first; otherwise wrap to the top.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < W; i++) begin
      w_mask[i] = (LW'(i) < r_ptr);
    end
  end

  assign w_free   = ~r_busy;
  assign w_loRes  = leftMostOne(w_free & w_mask);
  assign w_allRes = leftMostOne(w_free);
  assign w_any    = w_allRes[LW];
  assign w_enc    = w_loRes[LW] ? w_loRes[LW-1:0] : w_allRes[LW-1:0];

  assign w_take      = r_stgVld & bus.alloc_rdy_i;
  assign w_fill      = ~r_stgVld | w_take;
  assign w_freeLegal = bus.free_vld_i & r_busy[bus.free_tag_i]
                       & ~(r_stgVld & (r_stgTag == bus.free_tag_i));

  always_comb begin
    w_busyNxt = r_busy;
    if (w_freeLegal) begin
      w_busyNxt[bus.free_tag_i] = 1'b0;
    end
    if (w_fill & w_any) begin
      w_busyNxt[w_enc] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_busy   <= '0;
      r_stgVld <= 1'b0;
      r_stgTag <= '0;
      r_ptr    <= '0;
      r_err    <= 1'b0;
    end else begin
      r_busy <= w_busyNxt;
      if (w_fill) begin
        r_stgVld <= w_any;
        if (w_any) begin
          r_stgTag <= w_enc;
          r_ptr    <= w_enc;
        end
      end
      if (bus.free_vld_i & ~w_freeLegal) begin
        r_err <= 1'b1;
      end
    end
  end

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < W; i++) begin
      w_pop = w_pop + (LW+1)'(r_busy[i]);
    end
  end

  assign bus.alloc_vld_o = r_stgVld;
  assign bus.alloc_tag_o = r_stgTag;
  assign busy_o          = r_busy;
  assign cnt_o           = w_pop - (LW+1)'(r_stgVld);
  assign full_o          = (cnt_o == (LW+1)'(W));
  assign err_o           = r_err;
endmodule

// File: tb/tb_tag_alloc.sv
// Directed bench for tag_alloc (W=8): expected tags are queued as stimulus is
// planned and popped on every take the allocator performs.
module tb_tag_alloc;
  logic       clk;
  logic       arst_n;
  logic [7:0] busy;
  logic [3:0] cnt;
  logic       full;
  logic       err;

  int checks   = 0;
  int failures = 0;
  int expQ[$];

  tag_alloc_if #(.W(8)) bus ();

  tag_alloc #(.W(8), .RADIX_N(4)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus),
    .busy_o (busy),
    .cnt_o  (cnt),
    .full_o (full),
    .err_o  (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", name, observed, expected);
    end
  endtask

  // Called at a negedge: a take will happen on the coming posedge.
  task automatic popAndCompare();
    int e;
    if (expQ.size() == 0) begin
      checkOutput("unexpected_take", 32'(bus.alloc_tag_o), 32'hFFFF_FFFF);
    end else begin
      e = expQ.pop_front();
      checkOutput("take_tag", 32'(bus.alloc_tag_o), 32'(e));
    end
  endtask

  task automatic applyStimulus(input logic rdy, input logic fv, input logic [2:0] ft);
    bus.alloc_rdy_i = rdy;
    bus.free_vld_i  = fv;
    bus.free_tag_i  = ft;
    if (rdy && bus.alloc_vld_o) popAndCompare();
    @(negedge clk);
    bus.alloc_rdy_i = 1'b0;
    bus.free_vld_i  = 1'b0;
    bus.free_tag_i  = '0;
  endtask

  task automatic checkQueueEmpty(input string name);
    checkOutput(name, 32'(expQ.size()), 32'd0);
    expQ.delete();
  endtask

  task automatic doReset();
    arst_n = 1'b0;
    @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    arst_n          = 1'b0;
    bus.alloc_rdy_i = 1'b0;
    bus.free_vld_i  = 1'b0;
    bus.free_tag_i  = '0;
    repeat (3) @(negedge clk);

    checkOutput("rst_vld", 32'(bus.alloc_vld_o), 32'd0);
    checkOutput("rst_tag", 32'(bus.alloc_tag_o), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_cnt", 32'(cnt), 32'd0);
    checkOutput("rst_full", 32'(full), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);

    // Drain: 7..0 back to back.
    arst_n = 1'b1;
    @(negedge clk);
    checkOutput("first_vld", 32'(bus.alloc_vld_o), 32'd1);
    checkOutput("first_tag", 32'(bus.alloc_tag_o), 32'd7);
    for (int t = 7; t >= 0; t--) expQ.push_back(t);
    repeat (8) applyStimulus(1'b1, 1'b0, 3'd0);
    checkQueueEmpty("drain_missing_takes");
    checkOutput("drain_vld", 32'(bus.alloc_vld_o), 32'd0);
    checkOutput("drain_full", 32'(full), 32'd1);
    checkOutput("drain_cnt", 32'(cnt), 32'd8);
    checkOutput("drain_busy", 32'(busy), 32'hFF);

    // Hold-off: staged tag stays put while not ready.
    doReset();
    repeat (5) applyStimulus(1'b0, 1'b0, 3'd0);
    checkOutput("hold_vld", 32'(bus.alloc_vld_o), 32'd1);
    checkOutput("hold_tag", 32'(bus.alloc_tag_o), 32'd7);
    checkOutput("hold_busy", 32'(busy), 32'h80);
    checkOutput("hold_cnt", 32'(cnt), 32'd0);
    expQ.push_back(7);
    applyStimulus(1'b1, 1'b0, 3'd0);
    checkOutput("hold_next_tag", 32'(bus.alloc_tag_o), 32'd6);
    checkOutput("hold_next_cnt", 32'(cnt), 32'd1);
    for (int t = 6; t >= 0; t--) expQ.push_back(t);
    repeat (7) applyStimulus(1'b1, 1'b0, 3'd0);
    checkQueueEmpty("hold_missing_takes");
    checkOutput("hold_full", 32'(full), 32'd1);

    // Wrap: free 5 and 2 from an exhausted pool.
    applyStimulus(1'b0, 1'b1, 3'd5);
    checkOutput("wrap_busy_after_free5", 32'(busy), 32'hDF);
    checkOutput("wrap_cnt_after_free5", 32'(cnt), 32'd7);
    checkOutput("wrap_vld_same_cycle", 32'(bus.alloc_vld_o), 32'd0);
    applyStimulus(1'b0, 1'b1, 3'd2);
    checkOutput("wrap_vld", 32'(bus.alloc_vld_o), 32'd1);
    checkOutput("wrap_tag", 32'(bus.alloc_tag_o), 32'd5);
    expQ.push_back(5);
    expQ.push_back(2);
    repeat (2) applyStimulus(1'b1, 1'b0, 3'd0);
    checkQueueEmpty("wrap_missing_takes");
    checkOutput("wrap_third_vld", 32'(bus.alloc_vld_o), 32'd0);
    checkOutput("wrap_full", 32'(full), 32'd1);
    checkOutput("wrap_cnt", 32'(cnt), 32'd8);

    // Free while full: visible next edge, restaged the edge after.
    applyStimulus(1'b0, 1'b1, 3'd3);
    checkOutput("ff_busy", 32'(busy), 32'hF7);
    checkOutput("ff_vld_n", 32'(bus.alloc_vld_o), 32'd0);
    applyStimulus(1'b0, 1'b0, 3'd0);
    checkOutput("ff_vld_n1", 32'(bus.alloc_vld_o), 32'd1);
    checkOutput("ff_tag_n1", 32'(bus.alloc_tag_o), 32'd3);
    checkOutput("ff_cnt_n1", 32'(cnt), 32'd7);
    checkOutput("ff_busy_n1", 32'(busy), 32'hFF);

    // Illegal frees.
    applyStimulus(1'b0, 1'b1, 3'd4);
    checkOutput("legal_free_err", 32'(err), 32'd0);
    checkOutput("legal_free_busy", 32'(busy), 32'hEF);
    applyStimulus(1'b0, 1'b1, 3'd4);
    checkOutput("ill_notbusy_err", 32'(err), 32'd1);
    checkOutput("ill_notbusy_busy", 32'(busy), 32'hEF);
    applyStimulus(1'b0, 1'b1, 3'd3);
    checkOutput("ill_staged_err", 32'(err), 32'd1);
    checkOutput("ill_staged_busy", 32'(busy), 32'hEF);
    checkOutput("ill_staged_vld", 32'(bus.alloc_vld_o), 32'd1);
    checkOutput("ill_staged_tag", 32'(bus.alloc_tag_o), 32'd3);

    // Async reset with five tags out.
    applyStimulus(1'b0, 1'b1, 3'd7);
    checkOutput("pre_rst_cnt", 32'(cnt), 32'd5);
    #2;
    arst_n = 1'b0;
    #1;
    checkOutput("arst_vld", 32'(bus.alloc_vld_o), 32'd0);
    checkOutput("arst_tag", 32'(bus.alloc_tag_o), 32'd0);
    checkOutput("arst_busy", 32'(busy), 32'd0);
    checkOutput("arst_cnt", 32'(cnt), 32'd0);
    checkOutput("arst_full", 32'(full), 32'd0);
    checkOutput("arst_err", 32'(err), 32'd0);
    @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    checkOutput("arst_first_vld", 32'(bus.alloc_vld_o), 32'd1);
    checkOutput("arst_first_tag", 32'(bus.alloc_tag_o), 32'd7);
    checkOutput("arst_first_busy", 32'(busy), 32'h80);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
